// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB3/APB4 completer holding a small register bank.
//   Register word index = paddr[2 +: log2(NUM_REGS)]:
//     0 ID (RO, ID_VALUE), 1 WAIT (RW, bits [3:0]),
//     2 XFER_CNT (bits [15:0], any write clears), 3.. SCRATCH (RW, full width).
//   Misaligned, out-of-range, and ID-write accesses complete with pslverr=1 and no effect.
//   WAIT sets the number of extra access cycles before pready is asserted.
// Optional feature macro: APB_SLV_PROT_EN adds pprot[2:0]. Unprivileged (pprot[0]=0)
//   accesses to WAIT or XFER_CNT then complete with pslverr=1 and no effect.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   paddr, psel, penable, pwrite, pwdata, pstrb   APB request
//   pready, prdata, pslverr                       APB response
//   wait_cfg           current WAIT register value
module apb_reg_slave #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           STRB_WIDTH = 4,
  parameter int unsigned           NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001,
  parameter logic [3:0]            WAIT_RESET = 4'd0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
`ifdef APB_SLV_PROT_EN
  input  logic [2:0]            pprot,
`endif
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic [3:0]            wait_cfg
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);
  localparam logic [IdxW-1:0] IdxId   = IdxW'(0);
  localparam logic [IdxW-1:0] IdxWait = IdxW'(1);
  localparam logic [IdxW-1:0] IdxXfer = IdxW'(2);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [3:0]            wait_q, wait_d;
  logic [15:0]           xfer_q, xfer_d;
  logic [DATA_WIDTH-1:0] scratch_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] scratch_d [NUM_REGS];

  logic [IdxW-1:0]       idx;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  prot_err;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idx     = addr_q[2 +: IdxW];
  // Any bit above the register window makes the access out of range.
  assign addr_hi = addr_q >> (IdxW + 2);

`ifdef APB_SLV_PROT_EN
  logic priv_q, priv_d;
  logic unused_prot;
  assign unused_prot = ^pprot[2:1];
  assign prot_err    = !priv_q && ((idx == IdxWait) || (idx == IdxXfer));
`else
  assign prot_err    = 1'b0;
`endif

  assign err = (addr_q[1:0] != 2'b00) || (addr_hi != '0) || (write_q && (idx == IdxId)) ||
               prot_err;

  // Completion is combinational from the registered state and the live handshake.
  assign pready   = (state_q == StAccess) && psel && penable && (cnt_q == 4'd0);
  assign pslverr  = pready && err;
  assign prdata   = (pready && !write_q && !err) ? rd_word : '0;
  assign wait_cfg = wait_q;

  always_comb begin
    rd_word = '0;
    if (idx == IdxId) begin
      rd_word = ID_VALUE;
    end else if (idx == IdxWait) begin
      rd_word[3:0] = wait_q;
    end else if (idx == IdxXfer) begin
      rd_word[15:0] = xfer_q;
    end else begin
      rd_word = scratch_q[idx];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    wait_d    = wait_q;
    xfer_d    = xfer_q;
    scratch_d = scratch_q;
`ifdef APB_SLV_PROT_EN
    priv_d    = priv_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          state_d = StAccess;
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          cnt_d   = wait_q;
`ifdef APB_SLV_PROT_EN
          priv_d  = pprot[0];
`endif
        end
      end
      StAccess: begin
        if (!psel) begin
          // Abort: nothing commits.
          state_d = StIdle;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (pready && !err) begin
      xfer_d = xfer_q + 16'd1;
      if (write_q) begin
        if (idx == IdxWait) begin
          if (strb_q[0]) begin
            wait_d = wdata_q[3:0];
          end
        end else if (idx == IdxXfer) begin
          // Clearing write is not itself counted.
          xfer_d = 16'd0;
        end else begin
          for (int k = 0; k < STRB_WIDTH; k++) begin
            if (strb_q[k]) begin
              scratch_d[idx][8*k +: 8] = wdata_q[8*k +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      wait_q    <= WAIT_RESET;
      xfer_q    <= 16'd0;
      scratch_q <= '{default: '0};
`ifdef APB_SLV_PROT_EN
      priv_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      wait_q    <= wait_d;
      xfer_q    <= xfer_d;
      scratch_q <= scratch_d;
`ifdef APB_SLV_PROT_EN
      priv_q    <= priv_d;
`endif
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Self-checking bench for apb_reg_slave (default build, NUM_REGS=16).
module tb_apb_reg_slave;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic [3:0]  wait_cfg;

  always #5 clk_i = ~clk_i;

  apb_reg_slave dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr),
    .wait_cfg (wait_cfg)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model of the register bank.
  logic [31:0] m_regs [16];
  int          m_wait;
  int          m_xfer;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_wait = 0;
    m_xfer = 0;
  endtask

  // Predict one completed transfer and update the model.
  task automatic model_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic exp_err,
                            output logic [31:0] exp_rd);
    int idx;
    idx     = int'(addr / 4) % 16;
    exp_err = (addr % 4 != 0) || (addr >= 64) || (wr && idx == 0);
    exp_rd  = 32'h0;
    if (!exp_err && !wr) begin
      case (idx)
        0:       exp_rd = 32'hA9B0_0001;
        1:       exp_rd = 32'(m_wait);
        2:       exp_rd = 32'(m_xfer);
        default: exp_rd = m_regs[idx];
      endcase
    end
    if (!exp_err) begin
      if (wr && idx == 2) begin
        m_xfer = 0;
      end else begin
        m_xfer = (m_xfer + 1) % 65536;
        if (wr && idx == 1) begin
          if (strb[0]) m_wait = int'(wdata[3:0]);
        end else if (wr && idx >= 3) begin
          for (int k = 0; k < 4; k++)
            if (strb[k]) m_regs[idx][8*k +: 8] = wdata[8*k +: 8];
        end
      end
    end
  endtask

  // One APB transfer; returns response and the access cycle in which pready rose.
  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rd, output logic err,
                     output int cyc, output logic ok);
    @(negedge clk_i);
    paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
    psel = 1'b1; penable = 1'b0;
    @(negedge clk_i);
    penable = 1'b1;
    cyc = 1;
    ok  = 1'b0;
    rd  = 32'h0;
    err = 1'b0;
    while (cyc <= 40) begin
      #1;
      if (pready === 1'b1) begin
        ok  = 1'b1;
        rd  = prdata;
        err = pslverr;
        break;
      end
      check("wait_pslverr", {31'b0, pslverr}, 32'h0);
      @(negedge clk_i);
      cyc++;
    end
    @(posedge clk_i);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic xfer_chk(input string tag, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] rd, exp_rd;
    logic        err, exp_err, ok;
    int          cyc, exp_cyc;
    exp_cyc = m_wait + 1;
    model_xfer(addr, wr, wdata, strb, exp_err, exp_rd);
    apb(addr, wr, wdata, strb, rd, err, cyc, ok);
    check({tag, "_done"}, {31'b0, ok}, 32'h1);
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
    check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, "_rd"}, rd, exp_rd);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        w;
    int          r;

    rst_i = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_pready", {31'b0, pready}, 32'h0);
    check("rst_pslverr", {31'b0, pslverr}, 32'h0);
    check("rst_prdata", prdata, 32'h0);
    check("rst_wait", {28'b0, wait_cfg}, 32'h0);
    rst_i = 1'b0;

    xfer_chk("id_read", 32'h00, 1'b0, 32'h0, 4'h0);
    xfer_chk("wait_wr3", 32'h04, 1'b1, 32'h3, 4'hF);
    check("wait_cfg3", {28'b0, wait_cfg}, 32'h3);
    xfer_chk("scr_rd0", 32'h0C, 1'b0, 32'h0, 4'h0);
    xfer_chk("strb_wr", 32'h0C, 1'b1, 32'hDEAD_BEEF, 4'b0101);
    xfer_chk("strb_rd", 32'h0C, 1'b0, 32'h0, 4'h0);
    check("strb_model", m_regs[3], 32'h00AD_00EF);
    xfer_chk("wait_wr0", 32'h04, 1'b1, 32'h0, 4'h1);

    xfer_chk("err_id_wr", 32'h00, 1'b1, 32'h1234_5678, 4'hF);
    xfer_chk("err_misal", 32'h02, 1'b0, 32'h0, 4'h0);
    xfer_chk("err_range", 32'h40, 1'b0, 32'h0, 4'h0);
    xfer_chk("xfer_rd", 32'h08, 1'b0, 32'h0, 4'h0);

    xfer_chk("clr_wr", 32'h08, 1'b1, 32'hFFFF_FFFF, 4'hF);
    xfer_chk("clr_rd", 32'h08, 1'b0, 32'h0, 4'h0);
    xfer_chk("good1", 32'h10, 1'b0, 32'h0, 4'h0);
    xfer_chk("good2", 32'h14, 1'b1, 32'h5555_AAAA, 4'h0);
    xfer_chk("cnt3_rd", 32'h08, 1'b0, 32'h0, 4'h0);

    // Abort a write mid-access with WAIT=2.
    xfer_chk("wait_wr2", 32'h04, 1'b1, 32'h2, 4'hF);
    @(negedge clk_i);
    paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(negedge clk_i);
    penable = 1'b1;
    #1;
    check("abort_pready", {31'b0, pready}, 32'h0);
    @(negedge clk_i);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk_i);
    xfer_chk("abort_rd", 32'h10, 1'b0, 32'h0, 4'h0);

    // Randomized traffic; WAIT writes mix in naturally.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 15)) * 4;
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      if (r == 1) a = 32'h40 + (32'($urandom_range(0, 255)) << 2);
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      xfer_chk($sformatf("rnd%0d", i), a, w, d, s);
    end
    check("rnd_wait_cfg", {28'b0, wait_cfg}, 32'(m_wait));

    // Reset pulsed during an access.
    xfer_chk("wait_wr5", 32'h04, 1'b1, 32'h5, 4'hF);
    @(negedge clk_i);
    paddr = 32'h18; pwrite = 1'b1; pwdata = 32'h1111_2222; pstrb = 4'hF;
    psel = 1'b1; penable = 1'b0;
    @(negedge clk_i);
    penable = 1'b1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_pready", {31'b0, pready}, 32'h0);
    check("midrst_wait", {28'b0, wait_cfg}, 32'h0);
    rst_i = 1'b0; psel = 1'b0; penable = 1'b0;
    model_reset();
    xfer_chk("postrst_wait", 32'h04, 1'b0, 32'h0, 4'h0);
    xfer_chk("postrst_scr", 32'h18, 1'b0, 32'h0, 4'h0);
    xfer_chk("postrst_cnt", 32'h08, 1'b0, 32'h0, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
